// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared IEEE-754 single-precision constants, operand struct and unpack helper
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int EXT_W = MAN_W + 4;   // hidden bit + mantissa + guard/round/sticky

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  // Biased exponent at which a result no longer fits and becomes infinity.
  localparam logic signed [9:0] EXP_MAX = 10'(2 * BIAS + 1);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant;     // hidden bit included, zero for zero/denormal
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp_unpacked_t;

  // Denormals are flushed to a signed zero here, so downstream only ever sees
  // normal numbers, zeros (exp=0, mant=0) or specials.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] w);
    fp_unpacked_t u;
    u.sign    = w[31];
    u.is_zero = (w[30:23] == '0);
    u.is_inf  = (w[30:23] == '1) && (w[22:0] == '0);
    u.is_nan  = (w[30:23] == '1) && (w[22:0] != '0);
    u.exp     = w[30:23];
    u.mant    = u.is_zero ? '0 : {1'b1, w[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_lzc27.sv
// rtl/fp_lzc27.sv - combinational leading-zero counter for the 27-bit extended mantissa
//
// Ports:
//   value  in  27  vector to scan from bit 26 downwards
//   count  out 5   number of leading zeros (27 when value is zero)
module fp_lzc27
  import fp_pkg::*;
(
  input  logic [EXT_W-1:0] value,
  output logic [4:0]       count
);

  // Scanning upwards lets the highest set bit make the final assignment.
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < EXT_W; i++) begin
      if (value[i]) count = 5'(EXT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipelined.sv
// rtl/fp_add_pipelined.sv - 4-stage IEEE-754 single-precision adder/subtractor with clock enable
//
// Ports:
//   clock      in   1   rising-edge clock
//   aclr_n     in   1   asynchronous active-low clear of every stage and the outputs
//   clk_en     in   1   advance enable; 0 freezes all pipeline state
//   in_valid   in   1   dataa/datab/op hold an operation this cycle
//   op         in   1   0 = dataa+datab, 1 = dataa-datab
//   dataa      in   32  operand A
//   datab      in   32  operand B
//   result     out  32  rounded result of the most recent completed operation
//   out_valid  out  1   result was produced on the last enabled edge
//
// Stage 1 unpacks/classifies/swaps, stage 2 aligns, stage 3 adds, stage 4 is the
// normalise/round/pack that loads result. An op sampled on enabled edge 1 is on
// result after enabled edge 4.
module fp_add_pipelined #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
) (
  input  logic                   clock,
  input  logic                   aclr_n,
  input  logic                   clk_en,
  input  logic                   in_valid,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   dataa,
  input  logic [EXP_W+MAN_W:0]   datab,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   out_valid
);
  import fp_pkg::*;

  // ---------------- stage 1: unpack, classify, order by magnitude ----------------
  fp_unpacked_t ua, ub;
  logic         a_ge_b;
  logic         spec_d;
  logic [31:0]  spec_val_d;

  assign ua     = fp_unpack(dataa);
  assign ub     = fp_unpack({datab[31] ^ op, datab[30:0]});
  assign a_ge_b = {ua.exp, ua.mant} >= {ub.exp, ub.mant};

  always_comb begin
    spec_d     = 1'b0;
    spec_val_d = '0;
    if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign))) begin
      spec_d     = 1'b1;
      spec_val_d = QNAN;
    end else if (ua.is_inf) begin
      spec_d     = 1'b1;
      spec_val_d = {ua.sign, POS_INF[30:0]};
    end else if (ub.is_inf) begin
      spec_d     = 1'b1;
      spec_val_d = {ub.sign, POS_INF[30:0]};
    end else if (ua.is_zero && ub.is_zero) begin
      // Only (-0)+(-0) keeps the negative sign in round-to-nearest.
      spec_d     = 1'b1;
      spec_val_d = {ua.sign & ub.sign, 31'b0};
    end
  end

  logic             s1_valid, s1_sign, s1_eff_sub, s1_spec;
  logic [31:0]      s1_spec_val;
  logic [EXP_W-1:0] s1_exp_x, s1_exp_y;
  logic [MAN_W:0]   s1_mant_x, s1_mant_y;

  // ---------------- stage 2: align smaller operand ----------------
  logic [EXP_W-1:0] shamt;
  logic [EXT_W-1:0] y_ext, y_shr, lost_mask, y_al;

  assign shamt = s1_exp_x - s1_exp_y;
  assign y_ext = {s1_mant_y, 3'b000};

  always_comb begin
    y_shr     = '0;
    lost_mask = '0;
    y_al      = '0;
    if (shamt >= 8'(EXT_W)) begin
      y_al = {{(EXT_W-1){1'b0}}, |s1_mant_y};
    end else begin
      y_shr     = y_ext >> shamt;
      lost_mask = ~({EXT_W{1'b1}} << shamt);
      y_al      = {y_shr[EXT_W-1:1], y_shr[0] | (|(y_ext & lost_mask))};
    end
  end

  logic             s2_valid, s2_sign, s2_eff_sub, s2_spec;
  logic [31:0]      s2_spec_val;
  logic [EXP_W-1:0] s2_exp;
  logic [EXT_W-1:0] s2_x, s2_y;

  // ---------------- stage 3: add/subtract ----------------
  // X is never smaller than Y, so the difference cannot go negative.
  logic [EXT_W:0] sum_d;
  assign sum_d = s2_eff_sub ? ({1'b0, s2_x} - {1'b0, s2_y})
                            : ({1'b0, s2_x} + {1'b0, s2_y});

  logic             s3_valid, s3_sign, s3_spec;
  logic [31:0]      s3_spec_val;
  logic [EXP_W-1:0] s3_exp;
  logic [EXT_W:0]   s3_sum;

  // ---------------- stage 4: normalise, round, pack ----------------
  logic [4:0]          lzc;
  logic [EXT_W-1:0]    m_norm;
  logic signed [9:0]   e_norm, e_fin;
  logic                round_up;
  logic [MAN_W+1:0]    m_rnd;
  logic [MAN_W-1:0]    frac;
  logic [31:0]         res_d;

  fp_lzc27 u_lzc (
    .value (s3_sum[EXT_W-1:0]),
    .count (lzc)
  );

  always_comb begin
    if (s3_sum[EXT_W]) begin
      // Carry-out: the bit dropped on the right folds into sticky.
      m_norm = {s3_sum[EXT_W:2], s3_sum[1] | s3_sum[0]};
      e_norm = $signed({2'b00, s3_exp}) + 10'sd1;
    end else begin
      m_norm = s3_sum[EXT_W-1:0] << lzc;
      e_norm = $signed({2'b00, s3_exp}) - $signed({5'b00000, lzc});
    end
    // Guard set and (round|sticky|lsb) set -> round up; tie with even lsb stays.
    round_up = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
    m_rnd    = {1'b0, m_norm[EXT_W-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    e_fin    = m_rnd[MAN_W+1] ? (e_norm + 10'sd1) : e_norm;
    frac     = m_rnd[MAN_W+1] ? m_rnd[MAN_W:1] : m_rnd[MAN_W-1:0];

    if (s3_spec)                res_d = s3_spec_val;
    else if (s3_sum == '0)      res_d = '0;
    else if (e_fin >= EXP_MAX)  res_d = s3_sign ? NEG_INF : POS_INF;
    else if (e_fin <= 10'sd0)   res_d = {s3_sign, 31'b0};
    else                        res_d = {s3_sign, e_fin[7:0], frac};
  end

  // ---------------- stage register banks ----------------
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      s1_valid    <= 1'b0;  s1_sign   <= 1'b0;  s1_eff_sub <= 1'b0;  s1_spec <= 1'b0;
      s1_spec_val <= '0;    s1_exp_x  <= '0;    s1_exp_y   <= '0;
      s1_mant_x   <= '0;    s1_mant_y <= '0;
      s2_valid    <= 1'b0;  s2_sign   <= 1'b0;  s2_eff_sub <= 1'b0;  s2_spec <= 1'b0;
      s2_spec_val <= '0;    s2_exp    <= '0;    s2_x       <= '0;    s2_y    <= '0;
      s3_valid    <= 1'b0;  s3_sign   <= 1'b0;  s3_spec    <= 1'b0;
      s3_spec_val <= '0;    s3_exp    <= '0;    s3_sum     <= '0;
      result      <= '0;
      out_valid   <= 1'b0;
    end else if (clk_en) begin
      s1_valid    <= in_valid;
      s1_sign     <= a_ge_b ? ua.sign : ub.sign;
      s1_eff_sub  <= ua.sign ^ ub.sign;
      s1_spec     <= spec_d;
      s1_spec_val <= spec_val_d;
      s1_exp_x    <= a_ge_b ? ua.exp  : ub.exp;
      s1_mant_x   <= a_ge_b ? ua.mant : ub.mant;
      s1_exp_y    <= a_ge_b ? ub.exp  : ua.exp;
      s1_mant_y   <= a_ge_b ? ub.mant : ua.mant;

      s2_valid    <= s1_valid;
      s2_sign     <= s1_sign;
      s2_eff_sub  <= s1_eff_sub;
      s2_spec     <= s1_spec;
      s2_spec_val <= s1_spec_val;
      s2_exp      <= s1_exp_x;
      s2_x        <= {s1_mant_x, 3'b000};
      s2_y        <= y_al;

      s3_valid    <= s2_valid;
      s3_sign     <= s2_sign;
      s3_spec     <= s2_spec;
      s3_spec_val <= s2_spec_val;
      s3_exp      <= s2_exp;
      s3_sum      <= sum_d;

      out_valid   <= s3_valid;
      if (s3_valid) result <= res_d;
    end
  end

endmodule
